// File: rtl/sram_wr_capture_fifo_if.sv
// Bundles the register-bank SRAM write port, the consumer stream and the
// overflow status of the capture FIFO. The FIFO uses the slave modport and the
// producer/consumer side uses the master modport.
interface sram_wr_capture_fifo_if #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 3
);
  logic [ADDR_W-1:0]     sram_addr_i;
  logic [DATA_W-1:0]     sram_data_i;
  logic                  sram_wr_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [ADDR_W-1:0]     out_addr_o;
  logic [DATA_W-1:0]     out_data_o;
  logic [DEPTH_LOG2:0]   level_o;
  logic                  full_o;
  logic                  ovf_o;
  logic [7:0]            ovf_cnt_o;
  logic                  ovf_clr_i;

  modport slave (
    input  sram_addr_i, sram_data_i, sram_wr_i, out_ready_i, ovf_clr_i,
    output out_valid_o, out_addr_o, out_data_o, level_o, full_o, ovf_o, ovf_cnt_o
  );

  modport master (
    output sram_addr_i, sram_data_i, sram_wr_i, out_ready_i, ovf_clr_i,
    input  out_valid_o, out_addr_o, out_data_o, level_o, full_o, ovf_o, ovf_cnt_o
  );
endinterface

// File: rtl/sram_wr_capture_fifo.sv
// Captures every SRAM write strobe as an {addr,data} entry in a small
// first-word-fall-through FIFO and presents it on a valid/ready stream.
// Writes arriving while full (without a same-cycle pop) are dropped and
// counted in a sticky, saturating overflow counter.
module sram_wr_capture_fifo #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  sram_wr_capture_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int EW    = ADDR_W + DATA_W;
  localparam logic [PW-1:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [EW-1:0] mem [DEPTH];
  // Registered head entry: this is what the consumer sees, so outputs never
  // depend combinationally on sram_wr_i or out_ready_i.
  logic [EW-1:0] head_reg, head_next;
  logic          ovf_reg;
  logic [7:0]    ovf_cnt_reg;

  logic [PW-1:0] level, rd_ptr_inc;
  logic          empty, full, pop, push, ovf_event;
  logic [EW-1:0] wr_entry;

  // Occupancy, handshake decisions and the next head entry.
  always_comb begin
    wr_entry   = {bus.sram_addr_i, bus.sram_data_i};
    level      = wr_ptr_reg - rd_ptr_reg;
    empty      = (wr_ptr_reg == rd_ptr_reg);
    full       = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                 (wr_ptr_reg[PW-2:0] == rd_ptr_reg[PW-2:0]);
    pop        = !empty && bus.out_ready_i;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    push       = bus.sram_wr_i && (!full || pop);
    ovf_event  = bus.sram_wr_i && full && !pop;
    rd_ptr_inc = rd_ptr_reg + PTR_ONE;
    head_next  = head_reg;
    if (pop) begin
      if (level == PTR_ONE) begin
        // Last entry leaves: the same-cycle write (if any) becomes head,
        // otherwise the popped entry stays on the outputs.
        if (push) head_next = wr_entry;
      end else begin
        // The slot after the head is never the one being written here.
        head_next = mem[rd_ptr_inc[PW-2:0]];
      end
    end else if (empty && push) begin
      head_next = wr_entry;
    end
  end

  // Storage array: written on accepted pushes only, no reset needed since
  // the pointers define which slots hold live entries.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem[wr_ptr_reg[PW-2:0]] <= wr_entry;
  end

  // Pointer, head register and overflow status update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      head_reg    <= '0;
      ovf_reg     <= 1'b0;
      ovf_cnt_reg <= 8'd0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_inc;
      head_reg <= head_next;
      if (ovf_event) begin
        // A drop in the same cycle as a clear restarts the count at one.
        ovf_reg <= 1'b1;
        if (bus.ovf_clr_i)          ovf_cnt_reg <= 8'd1;
        else if (ovf_cnt_reg != 8'hFF) ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
      end else if (bus.ovf_clr_i) begin
        ovf_reg     <= 1'b0;
        ovf_cnt_reg <= 8'd0;
      end
    end
  end

  assign bus.out_valid_o = !empty;
  assign bus.out_addr_o  = head_reg[EW-1:DATA_W];
  assign bus.out_data_o  = head_reg[DATA_W-1:0];
  assign bus.level_o     = level;
  assign bus.full_o      = full;
  assign bus.ovf_o       = ovf_reg;
  assign bus.ovf_cnt_o   = ovf_cnt_reg;
endmodule
